// File: rtl/tx_link_seq_pkg.sv
// rtl/tx_link_seq_pkg.sv - state encoding and timing defaults for the TX link bring-up sequencer
package tx_link_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_MUX_REL  = 3'd2,
    ST_PRBS_REL = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  localparam int RST_CYC_DEF    = 8;
  localparam int MUX_SETTLE_DEF = 4;
  localparam int FLUSH_CYC_DEF  = 16;
  localparam int ERR_W_DEF      = 16;

  // Dwell timer only ever counts up to the longest dwell minus one.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tx_err_sched.sv
// rtl/tx_err_sched.sv - periodic single-cycle error injection timer for the RUN state
// err_cnt counter exists only when TX_LINK_SEQ_ERR_CNT_EN is defined; otherwise tied to zero.
module tx_err_sched
  import tx_link_seq_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             err_en,
  input  logic [ERR_W-1:0] err_period,
  output logic             inj_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [ERR_W-1:0] cnt;
  logic [ERR_W:0]   cnt_inc;
  logic             active;
  logic             hit;

  assign active  = run & err_en & (err_period != '0);
  assign cnt_inc = {1'b0, cnt} + {{ERR_W{1'b0}}, 1'b1};
  // Compare as >= so a period lowered below the running count fires at once.
  assign hit     = cnt_inc >= {1'b0, err_period};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      inj_err <= 1'b0;
    end else if (!active) begin
      cnt     <= '0;
      inj_err <= 1'b0;
    end else if (hit) begin
      cnt     <= '0;
      inj_err <= 1'b1;
    end else begin
      cnt     <= cnt_inc[ERR_W-1:0];
      inj_err <= 1'b0;
    end
  end

`ifdef TX_LINK_SEQ_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (active && hit && (err_cnt != '1)) begin
      err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_cnt    = '0;
`endif

endmodule

// File: rtl/tx_link_seq.sv
// rtl/tx_link_seq.sv - TX serializer bring-up sequencer: mux/PRBS reset release, clock-enable, error injection
// Optional err_cnt counter is enabled with TX_LINK_SEQ_ERR_CNT_EN.
module tx_link_seq
  import tx_link_seq_pkg::*;
#(
  parameter int RST_CYC    = RST_CYC_DEF,
  parameter int MUX_SETTLE = MUX_SETTLE_DEF,
  parameter int FLUSH_CYC  = FLUSH_CYC_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             err_en,
  input  logic [ERR_W-1:0] err_period,
  output logic             mux_rst,
  output logic             prbs_rst,
  output logic             prbs_cke,
  output logic             inj_err,
  output logic             busy,
  output logic             link_up,
  output logic [2:0]       state_o,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int TMR_W = tmr_width(RST_CYC, MUX_SETTLE, FLUSH_CYC);

  state_t           state, state_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             run;
  logic             clr;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr + {{(TMR_W-1){1'b0}}, 1'b1};
    case (state)
      ST_IDLE: begin
        tmr_nx = '0;
        if (start) state_nx = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (tmr == TMR_W'(RST_CYC - 1)) begin
          state_nx = ST_MUX_REL;
          tmr_nx   = '0;
        end
      end
      ST_MUX_REL: begin
        if (tmr == TMR_W'(MUX_SETTLE - 1)) begin
          state_nx = ST_PRBS_REL;
          tmr_nx   = '0;
        end
      end
      ST_PRBS_REL: begin
        if (tmr == TMR_W'(FLUSH_CYC - 1)) begin
          state_nx = ST_RUN;
          tmr_nx   = '0;
        end
      end
      ST_RUN: tmr_nx = '0;
      default: begin
        state_nx = ST_IDLE;
        tmr_nx   = '0;
      end
    endcase
    // Abort wins over everything, including a simultaneous start.
    if (stop) begin
      state_nx = ST_IDLE;
      tmr_nx   = '0;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      mux_rst  <= 1'b1;
      prbs_rst <= 1'b1;
      prbs_cke <= 1'b0;
      busy     <= 1'b0;
      link_up  <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      mux_rst  <= (state_nx == ST_IDLE) || (state_nx == ST_ASSERT);
      prbs_rst <= (state_nx == ST_IDLE) || (state_nx == ST_ASSERT) || (state_nx == ST_MUX_REL);
      prbs_cke <= (state_nx == ST_PRBS_REL) || (state_nx == ST_RUN);
      busy     <= (state_nx != ST_IDLE);
      link_up  <= (state_nx == ST_RUN);
    end
  end

  assign state_o = state;
  // Timer runs only while staying in RUN; entry starts from zero and exit clears on the same edge.
  assign run     = (state == ST_RUN) && (state_nx == ST_RUN);
  assign clr     = (state == ST_IDLE) && (state_nx == ST_ASSERT);

  tx_err_sched #(.ERR_W(ERR_W)) u_err_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clr        (clr),
    .err_en     (err_en),
    .err_period (err_period),
    .inj_err    (inj_err),
    .err_cnt    (err_cnt)
  );

endmodule
